// File: rtl/isa_pkg.sv
// Instruction-set constants and the field-to-word encoder shared by the
// program loader and anything else that needs to build instruction words.
package isa_pkg;

    localparam logic [3:0] OP_OR     = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_AND_L  = 4'h2;
    localparam logic [3:0] OP_OR_L   = 4'h3;
    localparam logic [3:0] OP_XOR_L  = 4'h4;
    localparam logic [3:0] OP_NOT_L  = 4'h5;
    localparam logic [3:0] OP_NOP    = 4'h6;
    localparam logic [3:0] OP_MUL    = 4'h7;
    localparam logic [3:0] OP_LD     = 4'hC;
    localparam logic [3:0] OP_SEL    = 4'h8;
    localparam logic [3:0] OP_MEM_RD = 4'hA;
    localparam logic [3:0] OP_MEM_WR = 4'hE;

    typedef enum logic [2:0] {
        KIND_ALU_R   = 3'd0,
        KIND_ALU_I   = 3'd1,
        KIND_LD_R    = 3'd2,
        KIND_LD_I    = 3'd3,
        KIND_SEL_R   = 3'd4,
        KIND_MEM_RD  = 3'd5,
        KIND_MEM_WR  = 3'd6,
        KIND_ILLEGAL = 3'd7
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [15:0] word;
        logic        illegal;
    } enc_t;

    // Bits not named by a format stay zero; op is only checked for ALU kinds.
    function automatic enc_t encode(
        input logic [2:0] kind,
        input logic [3:0] op,
        input logic [2:0] rg,
        input logic [7:0] imm,
        input logic [9:0] addr
    );
        enc_t r;
        r.word    = 16'h0000;
        r.illegal = 1'b0;
        case (kind)
            KIND_ALU_R: begin
                r.word    = {op, 9'b0, rg};
                r.illegal = op[3];
            end
            KIND_ALU_I: begin
                r.word    = {op, 3'b0, 1'b1, imm};
                r.illegal = op[3];
            end
            KIND_LD_R:   r.word = {OP_LD, 9'b0, rg};
            KIND_LD_I:   r.word = {OP_LD, 3'b0, 1'b1, imm};
            KIND_SEL_R:  r.word = {OP_SEL, 9'b0, rg};
            KIND_MEM_RD: r.word = {OP_MEM_RD, 2'b0, addr};
            KIND_MEM_WR: r.word = {OP_MEM_WR, 2'b0, addr};
            default:     r.illegal = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/instruction_fifo.sv
// Small synchronous FIFO of encoded words; head is visible combinationally
// so a word pushed at one edge can be popped in the very next cycle.
module instruction_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        srst,
    input  logic        push,
    input  logic [15:0] wdata,
    input  logic        pop,
    output logic [15:0] head,
    output logic        full,
    output logic        empty
);
    localparam int IW = $clog2(DEPTH);

    logic [IW:0]  wr_ptr_reg, rd_ptr_reg;
    logic [15:0]  mem_reg [DEPTH];
    logic         do_push, do_pop;

    assign full    = (wr_ptr_reg[IW] != rd_ptr_reg[IW]) &&
                     (wr_ptr_reg[IW-1:0] == rd_ptr_reg[IW-1:0]);
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_reg[rd_ptr_reg[IW-1:0]];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            localparam logic [IW-1:0] IDX = gi;
            always_ff @(posedge clk) begin
                if (do_push && wr_ptr_reg[IW-1:0] == IDX) begin
                    mem_reg[gi] <= wdata;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

endmodule

// File: rtl/instruction_encoder_loader.sv
// Encodes instruction field sets into 16-bit words and streams them into
// program memory starting at a base address, buffered through a small FIFO.
module instruction_encoder_loader
    import isa_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int PM_AW      = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PM_AW-1:0] base_addr,
    input  logic [PM_AW:0]   word_count,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_kind,
    input  logic [3:0]       in_alu_op,
    input  logic [2:0]       in_reg,
    input  logic [7:0]       in_imm,
    input  logic [9:0]       in_addr,
    input  logic             pm_busy,
    output logic             pm_wr_en,
    output logic [PM_AW-1:0] pm_addr,
    output logic [15:0]      pm_wdata,
    output logic             busy,
    output logic             done,
    output logic             err
);
    state_e           state_reg, state_next;
    logic [PM_AW-1:0] base_reg;
    logic [PM_AW:0]   count_reg, accepted_reg, written_reg, accepted_inc;
    logic             err_reg;
    enc_t             enc;
    logic             handshake, push, last_accept, active;
    logic             fifo_full, fifo_empty;
    logic [15:0]      fifo_head;

    assign enc          = encode(in_kind, in_alu_op, in_reg, in_imm, in_addr);
    assign handshake    = in_valid && in_ready;
    assign push         = handshake && !enc.illegal;
    assign accepted_inc = accepted_reg + 1'b1;
    assign last_accept  = push && (accepted_inc == count_reg);
    assign active       = (state_reg == ST_LOAD) || (state_reg == ST_DRAIN);

    instruction_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .srst  (rst),
        .push  (push),
        .wdata (enc.word),
        .pop   (pm_wr_en),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start) state_next = (word_count == '0) ? ST_DONE : ST_LOAD;
            ST_LOAD:  if (last_accept) state_next = ST_DRAIN;
            ST_DRAIN: if (written_reg == count_reg && fifo_empty) state_next = ST_DONE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_reg == ST_LOAD) && !fifo_full && (accepted_reg < count_reg);
        pm_wr_en = active && !fifo_empty && !pm_busy;
        busy     = (state_reg != ST_IDLE);
        done     = (state_reg == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_reg     <= '0;
            count_reg    <= '0;
            accepted_reg <= '0;
            written_reg  <= '0;
            err_reg      <= 1'b0;
        end else if (state_reg == ST_IDLE && start) begin
            base_reg     <= base_addr;
            count_reg    <= word_count;
            accepted_reg <= '0;
            written_reg  <= '0;
            err_reg      <= 1'b0;
        end else begin
            if (push)                     accepted_reg <= accepted_inc;
            if (pm_wr_en)                 written_reg  <= written_reg + 1'b1;
            if (handshake && enc.illegal) err_reg      <= 1'b1;
        end
    end

    // Address wraps naturally at the PM_AW-bit boundary.
    assign pm_addr  = base_reg + written_reg[PM_AW-1:0];
    assign pm_wdata = (active && !fifo_empty) ? fifo_head : 16'h0000;
    assign err      = err_reg;

endmodule
